// File: rtl/fp_sqrt_iterative_pkg.sv
// fp_sqrt_iterative_pkg: shared types and constants for the iterative FP square-root unit.
package fp_sqrt_iterative_pkg;
  localparam int EXPO_WIDTH = 11;
  localparam int FRAC_WIDTH = 52;
  localparam int BIAS = 1023;
  localparam int ID_WIDTH = 4;
  localparam int SQRT_ROOT_BITS_D = 55;
  localparam int SQRT_ROOT_BITS_S = 26;
  localparam logic [63:0] CANONICAL_NAN_D = 64'h7FF8_0000_0000_0000;
  localparam int SC_ZERO = 0, SC_INF = 1, SC_QNAN = 2, SC_SNAN = 3;
  typedef logic [ID_WIDTH-1:0] id_t;
  typedef logic [2:0] rm_t;
  typedef struct packed {
    logic fp_single_en;
  } cpu_config_t;
  localparam cpu_config_t EXAMPLE_CONFIG = '{fp_single_en: 1'b1};
  typedef enum logic [1:0] {IDLE, ITER, SPECIAL, DONE} fp_sqrt_state_t;
  typedef struct packed {
    logic [63:0] rs1;
    logic rs1_hidden;
    logic [3:0] special_case;
    logic [5:0] rs1_prenormalize_shift_amt;
    rm_t rm;
    logic single;
  } fp_sqrt_inputs_t;
  typedef struct packed {
    logic sign;
    logic [EXPO_WIDTH-1:0] expo;
    logic [FRAC_WIDTH-1:0] frac;
    logic [2:0] grs;
    logic hidden;
    rm_t rm;
    logic single;
    logic invalid;
    logic special;
  } fp_sqrt_result_t;
endpackage

// File: rtl/fp_sqrt_iterative_step.sv
// fp_sqrt_step: one combinational restoring square-root step producing a single root bit.
module fp_sqrt_step #(
  parameter int REM_W = 57,
  parameter int Q_W = 55
) (
  input  logic [REM_W-1:0] rem,
  input  logic [Q_W-1:0]   root,
  input  logic [1:0]       rad,
  output logic [REM_W-1:0] rem_n,
  output logic             q_bit
);
  logic borrow;
  logic [1:0] unused_hi;
  logic [REM_W-1:0] diff;
  assign {borrow, unused_hi, diff} = {1'b0, rem, rad} - (REM_W+3)'({root, 2'b01});
  assign q_bit = ~borrow;
  assign rem_n = borrow ? {rem[REM_W-3:0], rad} : diff;
endmodule

// File: rtl/fp_sqrt_iterative.sv
// fp_sqrt_iterative: iterative unrounded FP square root; FP_SQRT_RADIX4_EN selects two root bits per cycle.
module fp_sqrt_iterative
  import fp_sqrt_iterative_pkg::*;
#(
  parameter cpu_config_t CONFIG = EXAMPLE_CONFIG
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  new_request,
  input  id_t                   id,
  output logic                  ready,
  input  fp_sqrt_inputs_t       args,
  output logic                  done,
  input  logic                  ack,
  output id_t                   done_id,
  output logic                  res_sign,
  output logic [EXPO_WIDTH-1:0] res_expo,
  output logic [FRAC_WIDTH-1:0] res_frac,
  output logic [2:0]            res_grs,
  output logic                  res_hidden,
  output rm_t                   res_rm,
  output logic                  res_single,
  output logic                  res_invalid,
  output logic                  res_special
);
`ifdef FP_SQRT_RADIX4_EN
  localparam int Q_W = SQRT_ROOT_BITS_D + 1, ITER_D = 28, ITER_S = 13, STEP = 2;
`else
  localparam int Q_W = SQRT_ROOT_BITS_D, ITER_D = SQRT_ROOT_BITS_D, ITER_S = SQRT_ROOT_BITS_S, STEP = 1;
`endif
  localparam int REM_W = SQRT_ROOT_BITS_D + 2, RAD_W = 2 * Q_W, X = Q_W - SQRT_ROOT_BITS_D;
  fp_sqrt_state_t state, state_n;
  fp_sqrt_result_t res;
  id_t id_q;
  logic [5:0] cnt;
  logic [RAD_W-1:0] rad;
  logic [REM_W-1:0] rem, rem_n;
  logic [Q_W-1:0] root, root_n;
  logic q1, extra, single_in, sign, nonzero, nan, inv, go_special;
  logic [FRAC_WIDTH-1:0] frac_in;
  logic [FRAC_WIDTH+1:0] mant;
  logic signed [EXPO_WIDTH+1:0] e;
  logic [EXPO_WIDTH-1:0] expo_r;
`ifdef FP_SQRT_RADIX4_EN
  logic q0;
  logic [REM_W-1:0] rem_m;
  fp_sqrt_step #(.REM_W(REM_W), .Q_W(Q_W)) u_step1 (
    .rem(rem), .root(root), .rad(rad[RAD_W-1 -: 2]), .rem_n(rem_m), .q_bit(q1)
  );
  fp_sqrt_step #(.REM_W(REM_W), .Q_W(Q_W)) u_step0 (
    .rem(rem_m), .root((root << 1) | Q_W'(q1)), .rad(rad[RAD_W-3 -: 2]), .rem_n(rem_n), .q_bit(q0)
  );
  assign root_n = (root << 2) | Q_W'({q1, q0});
  assign extra = root_n[0];
`else
  fp_sqrt_step #(.REM_W(REM_W), .Q_W(Q_W)) u_step (
    .rem(rem), .root(root), .rad(rad[RAD_W-1 -: 2]), .rem_n(rem_n), .q_bit(q1)
  );
  assign root_n = (root << 1) | Q_W'(q1);
  assign extra = 1'b0;
`endif
  // Subnormals arrive prenormalized with hidden=0; their effective biased exponent is 1.
  always_comb begin
    single_in = args.single & CONFIG.fp_single_en;
    sign = args.rs1[63];
    nonzero = ~args.special_case[SC_ZERO];
    nan = args.special_case[SC_QNAN] | args.special_case[SC_SNAN];
    inv = args.special_case[SC_SNAN] | (~nan & sign & nonzero);
    go_special = |args.special_case | (sign & nonzero);
    frac_in = single_in ? {args.rs1[51:29], 29'b0} : args.rs1[51:0];
    mant = {2'b01, frac_in};
    e = (EXPO_WIDTH+2)'($signed({2'b0, args.rs1[62:52] | {{(EXPO_WIDTH-1){1'b0}}, ~args.rs1_hidden}})
        - BIAS - $signed({1'b0, args.rs1_prenormalize_shift_amt}));
    expo_r = EXPO_WIDTH'((e >>> 1) + BIAS);
  end
  always_comb begin
    state_n = state == IDLE    ? (new_request ? (go_special ? SPECIAL : ITER) : IDLE)
            : state == ITER    ? (cnt == 6'd0 ? DONE : ITER)
            : state == SPECIAL ? DONE
            : (ack ? IDLE : DONE);
    ready = state == IDLE;
    done = state == DONE;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk)
    if (rst) begin
      res.invalid <= 1'b0;
      res.special <= 1'b0;
    end else if (state == IDLE && new_request) begin
      id_q <= id;
      rad <= {e[0] ? mant << 1 : mant, {(RAD_W-FRAC_WIDTH-2){1'b0}}};
      rem <= '0;
      root <= '0;
      cnt <= 6'(single_in ? ITER_S - 1 : ITER_D - 1);
      res.rm <= args.rm;
      res.single <= single_in;
      res.grs <= '0;
      res.invalid <= inv;
      res.special <= go_special;
      res.sign <= (nan | inv) ? CANONICAL_NAN_D[63] : sign;
      res.expo <= (nan | inv) ? CANONICAL_NAN_D[62:52] : args.special_case[SC_ZERO] ? '0
                : args.special_case[SC_INF] ? '1 : expo_r;
      res.frac <= (nan | inv) ? CANONICAL_NAN_D[51:0] : '0;
      res.hidden <= nonzero;
    end else if (state == ITER) begin
      rad <= rad << (2 * STEP);
      rem <= rem_n;
      root <= root_n;
      cnt <= cnt - 6'd1;
      if (cnt == 6'd0) begin
        res.hidden <= res.single ? root_n[25] : root_n[54+X];
        res.frac <= res.single ? {root_n[24:2], 29'b0} : root_n[53+X:2+X];
        res.grs <= res.single ? {root_n[1:0], |rem_n} : {root_n[1+X:X], |rem_n | extra};
      end
    end
  assign done_id = id_q;
  assign res_sign = res.sign;
  assign res_expo = res.expo;
  assign res_frac = res.frac;
  assign res_grs = res.grs;
  assign res_hidden = res.hidden;
  assign res_rm = res.rm;
  assign res_single = res.single;
  assign res_invalid = res.invalid;
  assign res_special = res.special;
endmodule
